// File: rtl/banner_mask_blend_if.sv
// rtl/banner_mask_blend_if.sv - handshake bundle for the data, mask and output streams
interface banner_mask_blend_if;
    logic        din_data_ready;
    logic        din_data_valid;
    logic        din_data_startofpacket;
    logic        din_data_endofpacket;
    logic [23:0] din_data_data;
    logic        din_mask_ready;
    logic        din_mask_valid;
    logic        din_mask_startofpacket;
    logic        din_mask_endofpacket;
    logic [7:0]  din_mask_data;
    logic        dout_ready;
    logic        dout_valid;
    logic        dout_startofpacket;
    logic        dout_endofpacket;
    logic [23:0] dout_data;

    modport slave (
        output din_data_ready, din_mask_ready,
        output dout_valid, dout_startofpacket, dout_endofpacket, dout_data,
        input  din_data_valid, din_data_startofpacket, din_data_endofpacket, din_data_data,
        input  din_mask_valid, din_mask_startofpacket, din_mask_endofpacket, din_mask_data,
        input  dout_ready
    );

    modport master (
        input  din_data_ready, din_mask_ready,
        input  dout_valid, dout_startofpacket, dout_endofpacket, dout_data,
        output din_data_valid, din_data_startofpacket, din_data_endofpacket, din_data_data,
        output din_mask_valid, din_mask_startofpacket, din_mask_endofpacket, din_mask_data,
        output dout_ready
    );
endinterface

// File: rtl/banner_mask_blend.sv
// rtl/banner_mask_blend.sv - joins pixel and mask streams and alpha-blends over a background colour
module banner_mask_blend #(
    parameter logic [23:0] BG_COLOR = 24'h000000
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [23:0]         bg_color,
    output logic                sync_error,
    banner_mask_blend_if.slave  s
);
    logic        hd_q, hd_d, hm_q, hm_d;
    logic [25:0] dh_q, dh_d;
    logic [9:0]  mh_q, mh_d;
    logic [23:0] bg_q, bg_sel;
    logic        v1_q, sop1_q, eop1_q;
    logic [47:0] p_q, p_d;
    logic        dout_valid_q, dout_sop_q, dout_eop_q, sync_error_q;
    logic [23:0] dout_data_q;
    logic        adv1, adv2, join_w, acc_d, acc_m;

    function automatic logic [15:0] mix(input logic [7:0] d, input logic [7:0] bg, input logic [7:0] m);
        return 16'(d) * 16'(m) + 16'(bg) * 16'(8'd255 - m);
    endfunction

    // Exact round-to-nearest of p/255 without a divider.
    function automatic logic [7:0] div255(input logic [15:0] p);
        logic [16:0] q;
        q = {1'b0, p} + 17'd128;
        return 8'((q + (q >> 8)) >> 8);
    endfunction

    assign adv2   = !dout_valid_q | s.dout_ready;
    assign adv1   = !v1_q | adv2;
    assign join_w = hd_q & hm_q & adv1;

    assign s.din_data_ready = !reset & (!hd_q | join_w);
    assign s.din_mask_ready = !reset & (!hm_q | join_w);
    assign acc_d = s.din_data_valid & s.din_data_ready;
    assign acc_m = s.din_mask_valid & s.din_mask_ready;

    assign hd_d = acc_d | (hd_q & !join_w);
    assign hm_d = acc_m | (hm_q & !join_w);
    assign dh_d = acc_d ? {s.din_data_startofpacket, s.din_data_endofpacket, s.din_data_data} : dh_q;
    assign mh_d = acc_m ? {s.din_mask_startofpacket, s.din_mask_endofpacket, s.din_mask_data} : mh_q;

    assign bg_sel = dh_q[25] ? bg_color : bg_q;
    assign p_d = {mix(dh_q[23:16], bg_sel[23:16], mh_q[7:0]),
                  mix(dh_q[15:8],  bg_sel[15:8],  mh_q[7:0]),
                  mix(dh_q[7:0],   bg_sel[7:0],   mh_q[7:0])};

    always_ff @(posedge clk) begin
        if (reset) begin
            hd_q         <= 1'b0;
            hm_q         <= 1'b0;
            dh_q         <= '0;
            mh_q         <= '0;
            bg_q         <= BG_COLOR;
            v1_q         <= 1'b0;
            sop1_q       <= 1'b0;
            eop1_q       <= 1'b0;
            p_q          <= '0;
            dout_valid_q <= 1'b0;
            dout_sop_q   <= 1'b0;
            dout_eop_q   <= 1'b0;
            dout_data_q  <= '0;
            sync_error_q <= 1'b0;
        end else begin
            hd_q <= hd_d;
            hm_q <= hm_d;
            dh_q <= dh_d;
            mh_q <= mh_d;
            sync_error_q <= join_w & ((dh_q[25] != mh_q[9]) | (dh_q[24] != mh_q[8]));
            if (join_w && dh_q[25]) begin
                bg_q <= bg_color;
            end
            if (adv1) begin
                v1_q <= join_w;
                if (join_w) begin
                    p_q    <= p_d;
                    sop1_q <= dh_q[25];
                    eop1_q <= dh_q[24];
                end
            end
            if (adv2) begin
                dout_valid_q <= v1_q;
                if (v1_q) begin
                    dout_data_q <= {div255(p_q[47:32]), div255(p_q[31:16]), div255(p_q[15:0])};
                    dout_sop_q  <= sop1_q;
                    dout_eop_q  <= eop1_q;
                end
            end
        end
    end

    assign s.dout_valid         = dout_valid_q;
    assign s.dout_startofpacket = dout_sop_q;
    assign s.dout_endofpacket   = dout_eop_q;
    assign s.dout_data          = dout_data_q;
    assign sync_error           = sync_error_q;
endmodule

// File: tb/tb_banner_mask_blend.sv
// tb/tb_banner_mask_blend.sv - self-checking bench for banner_mask_blend
module tb_banner_mask_blend;
    localparam logic [23:0] RST_BG = 24'h0A0B0C;

    typedef struct {
        logic [23:0] pix;
        logic        sop;
        logic        eop;
    } dbeat_t;
    typedef struct {
        logic [7:0] m;
        logic       sop;
        logic       eop;
    } mbeat_t;
    typedef struct {
        logic [23:0] pix;
        logic [7:0]  m;
        logic [23:0] bg;
        logic [23:0] exp;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [23:0] bg_color = 24'h0;
    logic        sync_error;

    banner_mask_blend_if bus();

    banner_mask_blend #(.BG_COLOR(RST_BG)) dut (
        .clk        (clk),
        .reset      (reset),
        .bg_color   (bg_color),
        .sync_error (sync_error),
        .s          (bus)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    dbeat_t      dq[$];
    mbeat_t      mq[$];
    logic [25:0] got[$];
    int          got_cyc[$];
    int          sync_pulses;
    int          di_at_mask;
    logic [23:0] model_bg = RST_BG;
    vec_t        vt[6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: round(p/255) where p is the ideal weighted sum.
    function automatic logic [23:0] ref_blend(input logic [23:0] d, input logic [7:0] m, input logic [23:0] bg);
        logic [23:0] r;
        for (int c = 0; c < 3; c++) begin
            int p;
            p = int'(d[8*c +: 8]) * int'(m) + int'(bg[8*c +: 8]) * (255 - int'(m));
            r[8*c +: 8] = 8'((2 * p + 255) / 510);
        end
        return r;
    endfunction

    task automatic idle_inputs();
        bus.din_data_valid = 1'b0;
        bus.din_data_startofpacket = 1'b0;
        bus.din_data_endofpacket = 1'b0;
        bus.din_data_data = 24'h0;
        bus.din_mask_valid = 1'b0;
        bus.din_mask_startofpacket = 1'b0;
        bus.din_mask_endofpacket = 1'b0;
        bus.din_mask_data = 8'h0;
    endtask

    task automatic run(input string name, input int d_delay, input int m_delay, input bit rnd,
                       input int bg_change_after, input logic [23:0] bg_new);
        int          di = 0;
        int          mi = 0;
        int          cyc = 0;
        int          extra = 0;
        bit          hold = 1'b0;
        logic [25:0] held = '0;
        got.delete();
        got_cyc.delete();
        sync_pulses = 0;
        di_at_mask = -1;
        while (got.size() < dq.size() && cyc < 2000) begin
            @(negedge clk);
            cyc++;
            if (hold) begin
                check({name, "_hold"}, {6'b0, bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data}, {6'b0, held});
            end
            if (bg_change_after >= 0 && got.size() > bg_change_after) bg_color = bg_new;
            bus.dout_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (di < dq.size() && cyc > d_delay && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.din_data_valid = 1'b1;
                bus.din_data_data = dq[di].pix;
                bus.din_data_startofpacket = dq[di].sop;
                bus.din_data_endofpacket = dq[di].eop;
            end else begin
                bus.din_data_valid = 1'b0;
            end
            if (mi < mq.size() && cyc > m_delay && (!rnd || $urandom_range(0, 3) != 0)) begin
                bus.din_mask_valid = 1'b1;
                bus.din_mask_data = mq[mi].m;
                bus.din_mask_startofpacket = mq[mi].sop;
                bus.din_mask_endofpacket = mq[mi].eop;
            end else begin
                bus.din_mask_valid = 1'b0;
            end
            #1;
            if (sync_error) sync_pulses++;
            if (bus.din_mask_valid && bus.din_mask_ready && mi == 0) di_at_mask = di;
            if (bus.din_data_valid && bus.din_data_ready) di++;
            if (bus.din_mask_valid && bus.din_mask_ready) mi++;
            if (bus.dout_valid && bus.dout_ready) begin
                got.push_back({bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data});
                got_cyc.push_back(cyc);
            end
            hold = bus.dout_valid && !bus.dout_ready;
            held = {bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data};
        end
        check({name, "_count"}, got.size(), dq.size());
        @(negedge clk);
        idle_inputs();
        bus.dout_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (sync_error) sync_pulses++;
            if (bus.dout_valid) extra++;
            @(negedge clk);
        end
        check({name, "_no_extra"}, extra, 0);
    endtask

    task automatic compare_out(input string name, input logic [23:0] sop_bg);
        for (int i = 0; i < dq.size() && i < got.size(); i++) begin
            logic [25:0] exp;
            if (dq[i].sop) model_bg = sop_bg;
            exp = {dq[i].sop, dq[i].eop, ref_blend(dq[i].pix, mq[i].m, model_bg)};
            check($sformatf("%s[%0d]", name, i), {6'b0, got[i]}, {6'b0, exp});
        end
    endtask

    task automatic load_const(input int n, input logic [23:0] pix, input logic [7:0] m);
        dq.delete();
        mq.delete();
        for (int i = 0; i < n; i++) begin
            dq.push_back('{pix: pix, sop: (i == 0), eop: (i == n - 1)});
            mq.push_back('{m: m, sop: (i == 0), eop: (i == n - 1)});
        end
    endtask

    task automatic load_rand(input int n);
        dq.delete();
        mq.delete();
        for (int i = 0; i < n; i++) begin
            dq.push_back('{pix: 24'($urandom), sop: (i == 0), eop: (i == n - 1)});
            mq.push_back('{m: 8'($urandom), sop: (i == 0), eop: (i == n - 1)});
        end
    endtask

    initial begin
        vt[0] = '{pix: 24'h123456, m: 8'hFF, bg: 24'hFFFFFF, exp: 24'h123456};
        vt[1] = '{pix: 24'hABCDEF, m: 8'h00, bg: 24'h102030, exp: 24'h102030};
        vt[2] = '{pix: 24'hFF0000, m: 8'h80, bg: 24'h0000FF, exp: 24'h80007F};
        vt[3] = '{pix: 24'hFFFFFF, m: 8'h01, bg: 24'h000000, exp: 24'h010101};
        vt[4] = '{pix: 24'h000000, m: 8'hFE, bg: 24'hFFFFFF, exp: 24'h010101};
        vt[5] = '{pix: 24'hC8C8C8, m: 8'h7F, bg: 24'h404040, exp: 24'h848484};

        idle_inputs();
        bus.dout_ready = 1'b1;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        check("rst_dout_valid", bus.dout_valid, 0);
        check("rst_dout_data", bus.dout_data, 0);
        check("rst_sop_eop", {bus.dout_startofpacket, bus.dout_endofpacket}, 0);
        check("rst_sync_error", sync_error, 0);
        check("rst_readies", {bus.din_data_ready, bus.din_mask_ready}, 0);
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("post_rst_readies", {bus.din_data_ready, bus.din_mask_ready}, 2'b11);

        // Single beat latency: accept at E, dout_valid visible only after E+2.
        @(negedge clk);
        bg_color = 24'hFFFFFF;
        bus.din_data_valid = 1'b1;
        bus.din_data_data = 24'h123456;
        bus.din_data_startofpacket = 1'b1;
        bus.din_data_endofpacket = 1'b1;
        bus.din_mask_valid = 1'b1;
        bus.din_mask_data = 8'hFF;
        bus.din_mask_startofpacket = 1'b1;
        bus.din_mask_endofpacket = 1'b1;
        @(negedge clk);
        idle_inputs();
        check("lat_after_E", bus.dout_valid, 0);
        @(negedge clk);
        check("lat_after_E1", bus.dout_valid, 0);
        @(negedge clk);
        check("lat_after_E2", bus.dout_valid, 1);
        check("lat_data", {6'b0, bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data}, {8'b11, 24'h123456});
        @(negedge clk);
        check("lat_drop", bus.dout_valid, 0);
        model_bg = 24'hFFFFFF;

        for (int i = 0; i < 6; i++) begin
            load_const(1, vt[i].pix, vt[i].m);
            bg_color = vt[i].bg;
            run($sformatf("vec%0d", i), 0, 0, 1'b0, -1, 24'h0);
            if (got.size() > 0) check($sformatf("vec%0d_data", i), got[0][23:0], vt[i].exp);
            model_bg = vt[i].bg;
        end

        load_const(8, 24'h123456, 8'hFF);
        bg_color = 24'hFFFFFF;
        run("opaque8", 0, 0, 1'b0, -1, 24'h0);
        compare_out("opaque8", 24'hFFFFFF);
        if (got.size() == 8) check("opaque8_rate", got_cyc[7] - got_cyc[0], 7);

        load_const(6, 24'hABCDEF, 8'h00);
        bg_color = 24'h102030;
        run("bgheld", 0, 0, 1'b0, 0, 24'h000000);
        compare_out("bgheld", 24'h102030);

        load_rand(6);
        bg_color = 24'h334455;
        run("mask_late", 0, 5, 1'b0, -1, 24'h0);
        compare_out("mask_late", 24'h334455);
        check("mask_late_hold", di_at_mask, 1);

        for (int f = 0; f < 10; f++) begin
            logic [23:0] fbg;
            fbg = 24'($urandom);
            load_rand(16);
            bg_color = fbg;
            run($sformatf("rnd%0d", f), 0, 0, 1'b1, -1, 24'h0);
            compare_out($sformatf("rnd%0d", f), fbg);
            check($sformatf("rnd%0d_sync", f), sync_pulses, 0);
        end

        load_rand(4);
        mq[0].sop = 1'b0;
        mq[1].sop = 1'b1;
        bg_color = 24'h0F0F0F;
        run("syncerr", 0, 0, 1'b0, -1, 24'h0);
        compare_out("syncerr", 24'h0F0F0F);
        check("syncerr_pulses", sync_pulses, 2);

        // Fill the pipe under backpressure, then reset mid-frame.
        @(negedge clk);
        bus.dout_ready = 1'b0;
        bus.din_data_valid = 1'b1;
        bus.din_data_data = 24'h777777;
        bus.din_data_startofpacket = 1'b1;
        bus.din_mask_valid = 1'b1;
        bus.din_mask_data = 8'h40;
        bus.din_mask_startofpacket = 1'b1;
        bg_color = 24'hFFFFFF;
        repeat (6) @(negedge clk);
        check("pre_rst_full", bus.dout_valid, 1);
        reset = 1'b1;
        #1;
        check("mid_rst_readies", {bus.din_data_ready, bus.din_mask_ready}, 0);
        @(negedge clk);
        idle_inputs();
        check("mid_rst_valid", bus.dout_valid, 0);
        check("mid_rst_out", {6'b0, bus.dout_startofpacket, bus.dout_endofpacket, bus.dout_data}, 0);
        check("mid_rst_sync", sync_error, 0);
        reset = 1'b0;
        bus.dout_ready = 1'b1;
        #1;
        check("mid_rst_release", {bus.din_data_ready, bus.din_mask_ready}, 2'b11);
        model_bg = RST_BG;

        dq.delete();
        mq.delete();
        dq.push_back('{pix: 24'h999999, sop: 1'b0, eop: 1'b1});
        mq.push_back('{m: 8'h00, sop: 1'b0, eop: 1'b1});
        run("bg_reset", 0, 0, 1'b0, -1, 24'h0);
        if (got.size() > 0) check("bg_reset_data", got[0][23:0], RST_BG);
        compare_out("bg_reset", 24'hFFFFFF);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
